gemm_cmd_queue: RTL
===================

GEMM_CMD_QUEUE -- requirements
Module: gemm_cmd_queue

Interface
REQ-001 Parameter DATA_W, default 32: operand and result width in bits.
REQ-002 Parameter DEPTH, default 4: command queue entries, power of two, at least 2.
REQ-003 Parameter LAT, default 5: engine busy cycles per command, at least 1.
REQ-004 Parameter MODE, default 0: 0 = multiply, 1 = multiply-accumulate.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 gemm_valid  in  1  command request, sampled each rising edge.
REQ-008 gemm_rdata1  in  DATA_W  operand A, qualified by gemm_valid.
REQ-009 gemm_rdata2  in  DATA_W  operand B, qualified by gemm_valid.
REQ-010 acc_clr  in  1  synchronous accumulator clear (MODE 1 only).
REQ-011 flag_clr  in  1  synchronous clear of ovf and drop.
REQ-012 gemm_ready  out  1  queue not full.
REQ-013 gemm_done  out  1  high when queue empty and engine IDLE.
REQ-014 result  out  DATA_W  last computed result, held until next WRITE.
REQ-015 result_valid  out  1  one-cycle pulse marking a new result.
REQ-016 ovf  out  1  sticky arithmetic overflow.
REQ-017 drop  out  1  sticky "command lost while full".

Function
REQ-018 Command accepted at a rising edge when gemm_valid=1 and gemm_ready=1; {A,B} written at the write pointer, count+1.
REQ-019 gemm_ready = (count != DEPTH), derived from registered count only; a pop in the same cycle does not free a slot for that cycle's push.
REQ-020 gemm_valid=1 with gemm_ready=0: command discarded, drop set next edge, queue unchanged.
REQ-021 Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
REQ-022 FSM states IDLE, LOAD, BUSY, WRITE.
REQ-023 IDLE: count != 0 -> LOAD, else stay.
REQ-024 LOAD: pop head entry into operand registers, busy counter = LAT-1, -> BUSY.
REQ-025 BUSY: busy counter == 0 -> WRITE, else decrement; BUSY lasts exactly LAT cycles.
REQ-026 WRITE: result updated, result_valid=1 this cycle only; count != 0 -> LOAD, else -> IDLE.
REQ-027 Latency: command accepted at edge k into an empty queue with FSM in IDLE -> result_valid high in the cycle after edge k+2+LAT.
REQ-028 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-029 MODE 0: result = low DATA_W bits of unsigned A*B; ovf set if the upper DATA_W product bits are nonzero.
REQ-030 MODE 1: acc = acc + A*B, truncated to DATA_W; result = new acc; ovf set on nonzero upper product bits or on carry out of the add.
REQ-031 acc_clr in IDLE, LOAD or BUSY: acc = 0 next edge.
REQ-032 acc_clr during WRITE: addition uses acc = 0, so result = A*B.
REQ-033 acc_clr in MODE 0 has no effect.
REQ-034 flag_clr clears ovf and drop; a same-cycle set event wins (flag stays 1).
REQ-035 gemm_done = (state == IDLE) && (count == 0), decoded from registers only.

Reset
REQ-036 rst=0 asynchronously forces: state IDLE, pointers 0, count 0, busy counter 0, acc 0.
REQ-037 rst=0 asynchronously forces outputs: result 0, result_valid 0, ovf 0, drop 0, gemm_ready 1, gemm_done 1.
REQ-038 Reset asserted mid-command: the in-flight command and all queued commands are discarded; no result_valid pulse follows reset release.
REQ-039 First command is accepted at the first rising edge after rst deasserts.

Verification
REQ-040 MODE 0, LAT=5: single command A=3, B=7 at edge k -> gemm_done low from cycle k+1; result=21 with a one-cycle result_valid after edge k+7; gemm_done high again after edge k+8.
REQ-041 DEPTH=4, 6 back-to-back commands, engine idle at start -> first 4 accepted plus the 5th (the pop frees a slot); 6th dropped: drop=1, exactly 5 result_valid pulses, in order.
REQ-042 MODE 1 commands (2,3), (4,5), then acc_clr, then (1,1) -> results 6, 26, 1.
REQ-043 MODE 0, DATA_W=32: A=0x10000, B=0x10000 -> result=0, ovf=1; flag_clr -> ovf=0 next edge.
REQ-044 rst pulsed low while BUSY with 2 entries queued -> all outputs at reset values immediately; no result_valid after release; new command A=2, B=2 -> result=4.
REQ-045 Pointer wrap: 10 sequential commands with DEPTH=4, operands (i, 1) for i=1..10 -> results 1..10 in order, no drop.

Source files
------------

// File: rtl/gemm_cmd_queue.sv
// GEMM command queue: FIFO of operand pairs feeding a fixed-latency
// multiply / multiply-accumulate engine with sticky status flags.
module gemm_cmd_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int LAT    = 5,
  parameter int MODE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gemm_valid,
  input  logic [DATA_W-1:0] gemm_rdata1,
  input  logic [DATA_W-1:0] gemm_rdata2,
  input  logic              acc_clr,
  input  logic              flag_clr,
  output logic              gemm_ready,
  output logic              gemm_done,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              ovf,
  output logic              drop
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  localparam logic [CW-1:0] BUSY_INIT = CW'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    BUSY,
    WRITE
  } state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;
  logic [CW-1:0]     busy_cnt;
  logic [DATA_W-1:0] op_a, op_b;
  logic [DATA_W-1:0] acc, result_q;

  logic                push, pop, set_drop;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   acc_in, wr_val;
  logic                wr_ovf;

  assign gemm_ready = (count != FULL);
  assign gemm_done  = (state == IDLE) && (count == '0);
  assign push       = gemm_valid & gemm_ready;
  assign set_drop   = gemm_valid & ~gemm_ready;
  assign pop        = (state == LOAD);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (count != '0) state_nx = LOAD;
      LOAD:  state_nx = BUSY;
      BUSY:  if (busy_cnt == '0) state_nx = WRITE;
      WRITE: state_nx = (count != '0) ? LOAD : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // acc_clr during WRITE zeroes the addend so the result is just A*B
  always_comb begin
    prod   = {{DATA_W{1'b0}}, op_a} * {{DATA_W{1'b0}}, op_b};
    acc_in = (MODE == 1 && !acc_clr) ? acc : '0;
    sum    = {1'b0, acc_in} + {1'b0, prod[DATA_W-1:0]};
    wr_val = (MODE == 1) ? sum[DATA_W-1:0] : prod[DATA_W-1:0];
    wr_ovf = (|prod[2*DATA_W-1:DATA_W]) | ((MODE == 1) & sum[DATA_W]);
  end

  assign result_valid = (state == WRITE);
  assign result       = (state == WRITE) ? wr_val : result_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= gemm_rdata1;
      mem_b[wr_ptr] <= gemm_rdata2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      busy_cnt <= '0;
      op_a     <= '0;
      op_b     <= '0;
      acc      <= '0;
      result_q <= '0;
      ovf      <= 1'b0;
      drop     <= 1'b0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (state == LOAD) begin
        op_a     <= mem_a[rd_ptr];
        op_b     <= mem_b[rd_ptr];
        busy_cnt <= BUSY_INIT;
      end else if (state == BUSY && busy_cnt != '0) begin
        busy_cnt <= busy_cnt - 1'b1;
      end
      if (state == WRITE) begin
        result_q <= wr_val;
        if (MODE == 1) acc <= wr_val;
      end else if (MODE == 1 && acc_clr) begin
        acc <= '0;
      end
      ovf  <= ((state == WRITE) & wr_ovf) | (ovf & ~flag_clr);
      drop <= set_drop | (drop & ~flag_clr);
    end
  end

endmodule
